instr_sequencer: RTL and testbench



---
 rtl/instr_sequencer_if.sv | 27 ++
 rtl/instr_sequencer.sv | 109 ++++++++++
 tb/tb_instr_sequencer.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/instr_sequencer_if.sv
// Instruction-stream interface between the program loader/controller and instr_sequencer.
// slave = the sequencer side; master = whoever loads the store and controls the run.
interface instr_sequencer_if #(
  parameter int INSTR_WIDTH = 20,
  parameter int PC_BITS     = 5
);
  logic                   load_en;
  logic [PC_BITS-1:0]     load_addr;
  logic [INSTR_WIDTH-1:0] load_data;
  logic                   start;
  logic                   stall;
  logic [INSTR_WIDTH-1:0] instruction;
  logic                   instr_valid;
  logic [PC_BITS-1:0]     pc;
  logic                   busy;
  logic                   done;

  modport master (
    output load_en, load_addr, load_data, start, stall,
    input  instruction, instr_valid, pc, busy, done
  );

  modport slave (
    input  load_en, load_addr, load_data, start, stall,
    output instruction, instr_valid, pc, busy, done
  );
endinterface

// File: rtl/instr_sequencer.sv
// Program store + PC feeding one instruction word per clock to simple_cpu.
// Optional macro INSTR_SEQ_LOOP_EN: halt/end-of-store wraps and keeps running, pulsing done per pass.
module instr_sequencer #(
  parameter int                     INSTR_WIDTH = 20,
  parameter int                     PC_BITS     = 5,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = {INSTR_WIDTH{1'b1}},
  parameter logic [INSTR_WIDTH-1:0] NOP_WORD    = {INSTR_WIDTH{1'b0}}
) (
  input logic              clk,
  input logic              rst,
  instr_sequencer_if.slave bus
);
  localparam int                 DEPTH  = 2 ** PC_BITS;
  localparam logic [PC_BITS-1:0] PC_MAX = {PC_BITS{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                 state, state_n;
  logic [PC_BITS-1:0]     pc_q, pc_n;
  logic [INSTR_WIDTH-1:0] instr_q, instr_n;
  logic                   vld_q, vld_n;
  logic                   busy_q, busy_n;
  logic                   done_q, done_n;
  logic [INSTR_WIDTH-1:0] mem [DEPTH];
  logic [INSTR_WIDTH-1:0] rd_word;

  assign rd_word = mem[pc_q];

  // Store has no reset so a program survives rst; writes are locked out while running.
  always_ff @(posedge clk) begin
    if (bus.load_en && state != RUN)
      mem[bus.load_addr] <= bus.load_data;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      pc_q    <= '0;
      instr_q <= NOP_WORD;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      pc_q    <= pc_n;
      instr_q <= instr_n;
      vld_q   <= vld_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
    end
  end

  always_comb begin
    state_n = state;
    pc_n    = pc_q;
    instr_n = NOP_WORD;
    vld_n   = 1'b0;
    busy_n  = busy_q;
    done_n  = done_q;
    case (state)
      IDLE, DONE: begin
        if (bus.start && !bus.load_en) begin
          state_n = RUN;
          pc_n    = '0;
          busy_n  = 1'b1;
          done_n  = 1'b0;
        end
      end
      RUN: begin
`ifdef INSTR_SEQ_LOOP_EN
        done_n = 1'b0;
`endif
        if (bus.stall) begin
          // hold pc, NOP already defaulted
        end else if (rd_word == HALT_WORD) begin
`ifdef INSTR_SEQ_LOOP_EN
          pc_n    = '0;
          done_n  = 1'b1;
`else
          state_n = DONE;
          busy_n  = 1'b0;
          done_n  = 1'b1;
`endif
        end else begin
          instr_n = rd_word;
          vld_n   = 1'b1;
          pc_n    = pc_q + 1'b1;
          // Last word of the store is an implicit halt; pc wraps to 0 either way.
          if (pc_q == PC_MAX) begin
`ifdef INSTR_SEQ_LOOP_EN
            done_n  = 1'b1;
`else
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
`endif
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  assign bus.instruction = instr_q;
  assign bus.instr_valid = vld_q;
  assign bus.pc          = pc_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_instr_sequencer.sv
// Table-driven bench for instr_sequencer: each vector's expected outputs go through a scoreboard queue.
module tb_instr_sequencer;
  localparam int IW = 20;
  localparam int PB = 5;
  localparam logic [IW-1:0] H = 20'hFFFFF;
  localparam logic [IW-1:0] N = 20'h00000;

  typedef struct {
    logic          rst, ld;
    logic [PB-1:0] addr;
    logic [IW-1:0] data;
    logic          start, stall;
    logic [IW-1:0] e_instr;
    logic          e_vld;
    logic [PB-1:0] e_pc;
    logic          e_busy, e_done;
  } vec_t;

  logic clk, rst;
  int   checks, errors, step;
  vec_t tbl [$];
  vec_t sb  [$];

  instr_sequencer_if #(.INSTR_WIDTH(IW), .PC_BITS(PB)) sif ();

  instr_sequencer #(.INSTR_WIDTH(IW), .PC_BITS(PB), .HALT_WORD(H), .NOP_WORD(N)) dut (
    .clk (clk),
    .rst (rst),
    .bus (sif.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(logic r, logic l, logic [PB-1:0] a, logic [IW-1:0] d,
                              logic s, logic st, logic [IW-1:0] ei, logic ev,
                              logic [PB-1:0] ep, logic eb, logic ed);
    vec_t v;
    v.rst = r; v.ld = l; v.addr = a; v.data = d; v.start = s; v.stall = st;
    v.e_instr = ei; v.e_vld = ev; v.e_pc = ep; v.e_busy = eb; v.e_done = ed;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h, want %h", name, step, act, exp);
    end
  endtask

  // Drive one cycle of stimulus, queue its expectation, compare just after the edge.
  task automatic apply(input vec_t v);
    vec_t e;
    @(negedge clk);
    rst           = v.rst;
    sif.load_en   = v.ld;
    sif.load_addr = v.addr;
    sif.load_data = v.data;
    sif.start     = v.start;
    sif.stall     = v.stall;
    sb.push_back(v);
    @(posedge clk);
    #1;
    e = sb.pop_front();
    check("instruction", 32'(sif.instruction), 32'(e.e_instr));
    check("instr_valid", 32'(sif.instr_valid), 32'(e.e_vld));
    check("pc",          32'(sif.pc),          32'(e.e_pc));
    check("busy",        32'(sif.busy),        32'(e.e_busy));
    check("done",        32'(sif.done),        32'(e.e_done));
    step++;
  endtask

  initial begin
    checks = 0; errors = 0; step = 0;
    rst = 1'b1;
    sif.load_en = 1'b0; sif.load_addr = '0; sif.load_data = '0;
    sif.start = 1'b0; sif.stall = 1'b0;

`ifdef INSTR_SEQ_LOOP_EN
    //          rst ld addr data      st stl  instr     v  pc busy done
    tbl.push_back(mk(1, 0, 0, 0,        0, 0, N,        0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 20'h0000A, 0, 0, N,       0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 20'h0000B, 0, 0, N,       0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2, H,        0, 0, N,        0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,        1, 0, N,        0, 0, 1, 0));
    for (int p = 0; p < 3; p++) begin
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 20'h0000A, 1, 1, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 20'h0000B, 1, 2, 1, 0));
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, N,         0, 0, 1, 1));
    end
    tbl.push_back(mk(1, 0, 0, 0,        0, 0, N,        0, 0, 0, 0));
    foreach (tbl[i]) apply(tbl[i]);
`else
    // Load A1,A2,HALT and run.
    tbl.push_back(mk(1, 0, 0, 0,         0, 0, N,         0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 0, 20'h10203, 0, 0, N,         0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 1, 20'h21405, 0, 0, N,         0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 2, H,         0, 0, N,         0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,         1, 0, N,         0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, 20'h10203, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, 20'h21405, 1, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, N,         0, 2, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, N,         0, 2, 0, 1));
    // Stall for two cycles after A.
    tbl.push_back(mk(0, 1, 0, 20'hAAAA1, 0, 0, N,         0, 2, 0, 1));
    tbl.push_back(mk(0, 1, 1, 20'hBBBB2, 0, 0, N,         0, 2, 0, 1));
    tbl.push_back(mk(0, 1, 2, 20'hCCCC3, 0, 0, N,         0, 2, 0, 1));
    tbl.push_back(mk(0, 1, 3, H,         0, 0, N,         0, 2, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,         1, 0, N,         0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, 20'hAAAA1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 1, N,         0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 1, N,         0, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, 20'hBBBB2, 1, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, 20'hCCCC3, 1, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, N,         0, 3, 0, 1));
    // Collisions: load+start writes without running; load and start in RUN ignored.
    tbl.push_back(mk(0, 1, 3, 20'h33333, 1, 0, N,         0, 3, 0, 1));
    tbl.push_back(mk(0, 1, 4, H,         0, 0, N,         0, 3, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0,         1, 0, N,         0, 0, 1, 0));
    tbl.push_back(mk(0, 1, 1, 20'h99999, 0, 0, 20'hAAAA1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         1, 0, 20'hBBBB2, 1, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, 20'hCCCC3, 1, 3, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, 20'h33333, 1, 4, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, N,         0, 4, 0, 1));
    // Reset on the third issued word, then replay from mem[0].
    tbl.push_back(mk(0, 0, 0, 0,         1, 0, N,         0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, 20'hAAAA1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, 20'hBBBB2, 1, 2, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, 20'hCCCC3, 1, 3, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0,         0, 0, N,         0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0,         1, 0, N,         0, 0, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, 20'hAAAA1, 1, 1, 1, 0));
    tbl.push_back(mk(0, 0, 0, 0,         0, 0, 20'hBBBB2, 1, 2, 1, 0));
    tbl.push_back(mk(1, 0, 0, 0,         0, 0, N,         0, 0, 0, 0));
    foreach (tbl[i]) apply(tbl[i]);

    // End of store: 32 non-halt words, last one issued together with the DONE transition.
    for (int i = 0; i < 32; i++)
      apply(mk(0, 1, PB'(i), 20'h01000 + IW'(i), 0, 0, N, 0, 0, 0, 0));
    apply(mk(0, 0, 0, 0, 1, 0, N, 0, 0, 1, 0));
    for (int i = 0; i < 32; i++)
      apply(mk(0, 0, 0, 0, 0, 0, 20'h01000 + IW'(i), 1, PB'(i + 1),
               (i == 31) ? 1'b0 : 1'b1, (i == 31) ? 1'b1 : 1'b0));
    apply(mk(0, 0, 0, 0, 0, 0, N, 0, 0, 0, 1));
    apply(mk(0, 0, 0, 0, 0, 0, N, 0, 0, 0, 1));
`endif

    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard: got %0d pending entries, want 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
